// File: rtl/paint_scanner.sv
// Raster scanner for the layer paint interface: sweeps paint_x/paint_y, merges layers by fixed priority
// and buffers pixels in a show-ahead FIFO; scanning only pauses between rows until a full row fits.
module paint_scanner #(
  parameter int          H_RES      = 320,
  parameter int          V_RES      = 480,
  parameter int          OFFSET     = 4,
  parameter int          N_LAYERS   = 4,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter int          FIFO_DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_start,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     new_frame,
  output logic signed [15:0]       paint_x,
  output logic signed [15:0]       paint_y,
  input  logic [N_LAYERS-1:0]      layer_enable,
  input  logic [16*N_LAYERS-1:0]   layer_color,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [15:0]              pix_data,
  output logic                     pix_sof,
  output logic                     pix_eol
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [15:0] X_START = 16'(-OFFSET);
  localparam logic signed [15:0] X_LAST  = 16'(H_RES - 1);
  localparam logic signed [15:0] Y_LAST  = 16'(V_RES - 1);
  localparam logic [AW:0]        DEPTH   = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]        ROW     = H_RES[AW:0];

  typedef enum logic [2:0] {IDLE, NEW, WAIT, SCAN, DRAIN} state_t;
  state_t state;

  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic [AW:0] free;
  logic        push;
  logic        pop;
  logic        sof;
  logic        eol;
  logic [15:0] merged;

  always_comb begin
    merged = BG_COLOR;
    for (int i = 0; i < N_LAYERS; i++)
      if (layer_enable[i]) merged = layer_color[16*i +: 16];
  end

  assign level     = wr_ptr - rd_ptr;
  assign pix_valid = (level != '0);
  assign pop       = pix_valid && pix_ready;
  assign push      = (state == SCAN) && !paint_x[15];
  assign sof       = (paint_x == '0) && (paint_y == '0);
  assign eol       = (paint_x == X_LAST);
  // An entry leaving this cycle already counts as free space.
  assign free      = DEPTH - level + {{AW{1'b0}}, pop};

  assign {pix_sof, pix_eol, pix_data} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {sof, eol, merged};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      new_frame  <= 1'b0;
      paint_x    <= X_START;
      paint_y    <= '0;
    end else begin
      frame_done <= 1'b0;
      new_frame  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= NEW;
            busy      <= 1'b1;
            new_frame <= 1'b1;
            paint_x   <= X_START;
            paint_y   <= '0;
          end
        end
        NEW:  state <= WAIT;
        WAIT: if (free >= ROW) state <= SCAN;
        SCAN: begin
          if (paint_x == X_LAST) begin
            paint_x <= X_START;
            if (paint_y == Y_LAST) begin
              state <= DRAIN;
            end else begin
              paint_y <= paint_y + 16'sd1;
              state   <= WAIT;
            end
          end else begin
            paint_x <= paint_x + 16'sd1;
          end
        end
        DRAIN: begin
          if (!pix_valid) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_paint_scanner.sv
// Bench for paint_scanner: coordinate-driven layer model with OFFSET lookahead feeds the DUT,
// and a queue of expected raster pixels scores the output stream.
module tb_paint_scanner;
  localparam int          H   = 8;
  localparam int          V   = 4;
  localparam int          OFF = 4;
  localparam int          NL  = 4;
  localparam int          FD  = 8;
  localparam logic [15:0] BG  = 16'hA5A5;
  localparam logic [15:0] XS  = 16'(-OFF);

  localparam int M_GEOM = 0;
  localparam int M_PRIO = 1;
  localparam int M_BG   = 2;
  localparam int M_RAND = 3;

  logic               clk;
  logic               rstn;
  logic               frame_start;
  logic               busy;
  logic               frame_done;
  logic               new_frame;
  logic signed [15:0] paint_x;
  logic signed [15:0] paint_y;
  logic [NL-1:0]      layer_enable;
  logic [16*NL-1:0]   layer_color;
  logic               pix_valid;
  logic               pix_ready;
  logic [15:0]        pix_data;
  logic               pix_sof;
  logic               pix_eol;

  paint_scanner #(
    .H_RES(H), .V_RES(V), .OFFSET(OFF), .N_LAYERS(NL), .BG_COLOR(BG), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .new_frame(new_frame), .paint_x(paint_x), .paint_y(paint_y), .layer_enable(layer_enable),
    .layer_color(layer_color), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  int n_chk;
  int n_err;
  int mode;
  int rdy_mode;
  logic man_rdy;
  int lvl;
  bit ovf;
  int nf_cnt;
  int fd_cnt;
  int cyc;
  int nf_cyc;
  int row_cyc[$];
  logic [17:0] exp_q[$];
  logic [NL-1:0] rnd_en [V][H];
  logic [15:0]   rnd_col [NL][V][H];
  logic [NL-1:0]    hen  [5];
  logic [16*NL-1:0] hcol [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic lay_en(input int i, input int x, input int y);
    case (mode)
      M_GEOM:  return i == 0;
      M_PRIO:  return (i == 0) || (i == 2 && x >= 2 && x <= 3);
      M_BG:    return 1'b0;
      default: return rnd_en[y][x][i];
    endcase
  endfunction

  function automatic logic [15:0] lay_col(input int i, input int x, input int y);
    case (mode)
      M_GEOM:  return {8'(y), 8'(x)};
      M_PRIO:  return (i == 2) ? 16'h2222 : ((i == 0) ? 16'h1111 : 16'hDEAD);
      M_BG:    return 16'h7777;
      default: return rnd_col[i][y][x];
    endcase
  endfunction

  // Reference: scan layers from the top down, first enabled one wins.
  function automatic logic [15:0] ref_pix(input int x, input int y);
    for (int i = NL - 1; i >= 0; i--)
      if (lay_en(i, x, y)) return lay_col(i, x, y);
    return BG;
  endfunction

  // Layer model: colour for (x+OFF, y), delivered OFF cycles later; also drives pix_ready.
  always begin : drv
    int lx;
    int ly;
    @(negedge clk);
    #1;
    for (int k = 4; k > 0; k--) begin
      hen[k]  = hen[k-1];
      hcol[k] = hcol[k-1];
    end
    lx = int'(paint_x) + OFF;
    ly = int'(paint_y);
    hen[0]  = '0;
    hcol[0] = '0;
    if (lx >= 0 && lx < H && ly >= 0 && ly < V)
      for (int i = 0; i < NL; i++) begin
        hen[0][i]           = lay_en(i, lx, ly);
        hcol[0][16*i +: 16] = lay_col(i, lx, ly);
      end
    layer_enable = hen[4];
    layer_color  = hcol[4];
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 3) != 0);
      default: pix_ready = man_rdy;
    endcase
  end

  always begin : mon
    logic [17:0] e;
    logic        stall_prev;
    logic [18:0] held;
    @(negedge clk);
    #2;
    cyc++;
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold", {13'b0, pix_valid, pix_sof, pix_eol, pix_data}, {13'b0, held});
      chk("valid", 32'(pix_valid), 32'(lvl > 0));
      if (new_frame) begin
        nf_cnt++;
        nf_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("done_empty", 32'(exp_q.size()), 0);
      end
      if (!paint_x[15]) begin
        lvl++;
        if (paint_x == 0) row_cyc.push_back(cyc);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk("extra_pix", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pix", {14'b0, pix_sof, pix_eol, pix_data}, {14'b0, e});
        end
        lvl--;
      end
      if (lvl > FD) ovf = 1'b1;
      stall_prev = pix_valid && !pix_ready;
      held       = {1'b1, pix_sof, pix_eol, pix_data};
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_nf"}, 32'(new_frame), 0);
    chk({tag, "_px"}, {16'b0, paint_x}, {16'b0, XS});
    chk({tag, "_py"}, {16'b0, paint_y}, 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
  endtask

  task automatic start_frame(input int m);
    mode = m;
    if (m == M_RAND)
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++) begin
          rnd_en[y][x] = NL'($urandom);
          for (int i = 0; i < NL; i++) rnd_col[i][y][x] = 16'($urandom);
        end
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back({(x == 0 && y == 0), (x == H - 1), ref_pix(x, y)});
    nf_cnt = 0;
    fd_cnt = 0;
    ovf    = 1'b0;
    row_cyc.delete();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit dbl);
    for (int i = 0; i < budget && fd_cnt == 0; i++) begin
      @(negedge clk);
      if (dbl) frame_start = (i == 20);
    end
    frame_start = 1'b0;
    chk("done_seen", 32'(fd_cnt != 0), 1);
    repeat (10) @(negedge clk);
    chk("one_done", fd_cnt, 1);
    chk("one_nf", nf_cnt, 1);
    chk("q_empty", 32'(exp_q.size()), 0);
    chk("idle", 32'(busy), 0);
    chk("no_ovf", 32'(ovf), 0);
  endtask

  initial begin : main
    bit found;
    n_chk = 0; n_err = 0; mode = M_GEOM; rdy_mode = 0; man_rdy = 1'b0;
    lvl = 0; ovf = 1'b0; nf_cnt = 0; fd_cnt = 0; cyc = 0; nf_cyc = 0;
    rstn = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Geometry, sequencing and throughput, with a frame_start while busy.
    start_frame(M_GEOM);
    wait_done(500, 1'b1);
    chk("rows", 32'(row_cyc.size()), V);
    if (row_cyc.size() == V) begin
      chk("nf_to_px0", 32'(row_cyc[0] - nf_cyc), OFF + 2);
      for (int r = 1; r < V; r++)
        chk("row_period", 32'(row_cyc[r] - row_cyc[r-1]), H + OFF + 1);
    end

    start_frame(M_PRIO);
    wait_done(500, 1'b0);
    start_frame(M_BG);
    wait_done(500, 1'b0);

    rdy_mode = 1;
    repeat (3) begin
      start_frame(M_RAND);
      wait_done(2000, 1'b0);
    end

    // Backpressure: stall after row 0 until exactly one row of space frees up.
    rdy_mode = 2;
    man_rdy  = 1'b0;
    start_frame(M_RAND);
    repeat (40) @(negedge clk);
    chk("bp_px", {16'b0, paint_x}, {16'b0, XS});
    chk("bp_py", {16'b0, paint_y}, 1);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_lvl", lvl, FD);
    repeat (7) begin
      man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("bp7_px", {16'b0, paint_x}, {16'b0, XS});
    chk("bp7_py", {16'b0, paint_y}, 1);
    chk("bp7_lvl", lvl, 1);
    man_rdy = 1'b1;
    @(negedge clk);
    man_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_resume", 32'(paint_x != XS), 1);
    man_rdy = 1'b1;
    wait_done(2000, 1'b0);

    // Reset in the middle of row 2.
    rdy_mode = 0;
    start_frame(M_GEOM);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (paint_y == 2 && !paint_x[15]) found = 1'b1;
    end
    chk("reach_row2", 32'(found), 1);
    rstn = 1'b0;
    exp_q.delete();
    lvl = 0;
    @(negedge clk);
    chk_reset("mid_rst");
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_rst", fd_cnt, 0);
    start_frame(M_GEOM);
    wait_done(500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/paint_scanner.md
Name: paint_scanner

Overview:
- Sink end of the layer paint interface. It generates the raster scan (paint_x, paint_y, new_frame) that every sprite or background layer consumes.
- It collects each layer's paint_enable/paint_color, merges them by fixed priority and buffers the resulting pixels in a FIFO.
- The FIFO drains through a valid/ready pixel stream toward the LCD writer.
- Scanning stalls only at row boundaries, because the layer pipelines cannot be frozen.

Parameters:
- H_RES, 320, pixels per row (paint_x range 0..H_RES-1).
- V_RES, 480, rows per frame (paint_y range 0..V_RES-1).
- OFFSET, 4, layer pipeline latency/lookahead; each row is scanned starting at paint_x = -OFFSET.
- N_LAYERS, 4, number of layer inputs; a higher index has higher priority.
- BG_COLOR, 16'h0000, RGB565 colour emitted when no layer is enabled.
- FIFO_DEPTH, 512, pixel FIFO entries; must be >= H_RES and a power of two.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low; clock clk.
- frame_start  in  1  pulse; starts one frame scan when idle.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse when the last pixel of the frame has left the stream.
- new_frame  out  1  one-cycle pulse to layers at frame begin.
- paint_x  out  16 signed  current scan column.
- paint_y  out  16 signed  current scan row.
- layer_enable  in  N_LAYERS  per-layer paint_enable; bit i belongs to layer i.
- layer_color  in  16*N_LAYERS  per-layer RGB565; layer i occupies [16i+15:16i].
- pix_valid  out  1  stream valid (FIFO non-empty).
- pix_ready  in  1  stream ready.
- pix_data  out  16  RGB565 pixel.
- pix_sof  out  1  marks pixel (0,0) of the frame.
- pix_eol  out  1  marks pixel x = H_RES-1 of each row.

Behaviour:
- Reset values: busy=0, frame_done=0, new_frame=0, paint_x=-OFFSET, paint_y=0, pix_valid=0. Reset flushes the FIFO and returns the FSM to IDLE; a mid-frame reset aborts the frame and no frame_done is issued.
- paint_x, paint_y and new_frame are registered outputs.

States:
- IDLE: on frame_start, set busy=1 and go to NEW. frame_start in any other state is ignored.
- NEW (exactly 1 cycle): new_frame=1, paint_y=0, paint_x=-OFFSET, then go to WAIT.
- WAIT: hold paint_x=-OFFSET. Go to SCAN when free FIFO entries >= H_RES, evaluated with the current-cycle pop counted.
- SCAN: paint_x increments by 1 every cycle from -OFFSET to H_RES-1 with no gaps.
  - The merge result sampled in the cycle where paint_x = k (k >= 0) is pixel (k, paint_y). Layer latency is compensated by OFFSET inside the layers.
  - On that cycle, push {sof = (k==0 && y==0), eol = (k==H_RES-1), colour}.
  - Cycles with paint_x < 0 push nothing.
  - At paint_x = H_RES-1: if paint_y = V_RES-1, go to DRAIN. Otherwise paint_y+1 and paint_x=-OFFSET take effect in the next cycle, and the FSM goes to WAIT.
- DRAIN: paint_x=-OFFSET. When the FIFO is empty, frame_done=1 for one cycle, busy=0, and the FSM goes to IDLE.
- Merge is combinational: the highest index i with layer_enable[i]=1 supplies the colour; if none is enabled, the colour is BG_COLOR.
- FIFO: show-ahead; pix_valid = !empty; pix_data/pix_sof/pix_eol reflect the head entry.
  - Pop when pix_valid && pix_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - The WAIT gating guarantees no overflow. Overflow is a design error; the bench asserts that it never occurs.
- Stream rules: data must be stable while pix_valid && !pix_ready, and pix_valid never drops without a pop.
- Throughput: with pix_ready held at 1, a row costs H_RES+OFFSET+1 cycles (the WAIT cycle included).

Test Plan:
- Geometry: H_RES=8, V_RES=4, OFFSET=4, pix_ready=1. The bench layer model computes its colour from (x+4, y) and delays it 4 cycles, with layer0 colour = {y[7:0], x[7:0]}. Required: 32 pixels in raster order with colours 0x0000..0x0307, pix_sof on the first pixel only, pix_eol on every 8th pixel, then one frame_done.
- Priority: layer0 always enabled (0x1111); layer2 enabled only for x in 2..3 (0x2222). Required: rows read 1111,1111,2222,2222,1111×4. With no layer enabled, BG_COLOR is emitted.
- Backpressure (FIFO_DEPTH=8, H_RES=8): hold pix_ready=0 after the first row. Required: FSM stays in WAIT with paint_x=-4, the FIFO level stays at 8, no pixel is lost or reordered, and scanning resumes only after 8 pops.
- Sequencing: a frame_start pulse while busy is ignored. new_frame is high exactly one cycle, before the first SCAN cycle of the frame. frame_done fires only once the FIFO is empty.
- Reset mid-frame: drop rstn while in SCAN on row 2. Required: the next cycle shows all outputs at reset values and pix_valid=0. A following frame_start produces a clean frame whose first popped pixel carries pix_sof=1.
